// File: rtl/stream_pack.sv
// stream_pack: packs an unstallable pixel stream into frame-tagged words behind a FIFO and valid/ready output.
module stream_pack #(
  parameter int CFG_DWIDTH  = 32,
  parameter int CFG_AWIDTH  = 5,
  parameter int CFG_FRAME   = 4,
  parameter int IMG_WIDTH   = 16,
  parameter int PACK_NB     = 4,
  parameter int FIFO_AWIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CFG_DWIDTH-1:0]          cfg_data,
  input  logic [CFG_AWIDTH-1:0]          cfg_addr,
  input  logic                           cfg_valid,
  input  logic [IMG_WIDTH-1:0]           up_data,
  input  logic                           up_val,
  output logic [IMG_WIDTH*PACK_NB-1:0]   dn_data,
  output logic [PACK_NB-1:0]             dn_keep,
  output logic                           dn_last,
  output logic                           dn_valid,
  input  logic                           dn_ready,
  output logic                           overflow,
  output logic [FIFO_AWIDTH:0]           level
);
  localparam int LW    = $clog2(PACK_NB);
  localparam int DW    = IMG_WIDTH * PACK_NB;
  localparam int EW    = DW + PACK_NB + 1;
  localparam int DEPTH = 1 << FIFO_AWIDTH;
  logic [CFG_DWIDTH-1:0]  frame_len;
  logic [31:0]            pix_cnt;
  logic [LW-1:0]          lane_idx;
  logic [DW-1:0]          acc_data, nxt_data;
  logic [PACK_NB-1:0]     acc_keep, nxt_keep;
  logic                   push_val;
  logic [EW-1:0]          push_word;
  logic [EW-1:0]          mem [DEPTH];
  logic [FIFO_AWIDTH:0]   wr_ptr, rd_ptr;
  logic                   cfg_wr, pix, eof, done, empty, full, push, pop;
  assign cfg_wr = cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_FRAME);
  assign pix    = up_val && !cfg_wr;
  assign eof    = frame_len != '0 && pix_cnt == 32'(frame_len - CFG_DWIDTH'(1));
  assign done   = pix && (lane_idx == LW'(PACK_NB - 1) || eof);
  always_comb begin
    nxt_data = acc_data;
    nxt_data[lane_idx*IMG_WIDTH +: IMG_WIDTH] = up_data;
    nxt_keep = acc_keep | (PACK_NB'(1) << lane_idx);
  end
  // Completed words are staged one cycle so the FIFO write is fully registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_len <= '0;
      pix_cnt   <= '0;
      lane_idx  <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      push_val  <= 1'b0;
      push_word <= '0;
    end else begin
      push_val <= done;
      if (done) push_word <= {nxt_data, nxt_keep, eof};
      if (cfg_wr) begin
        frame_len <= cfg_data;
        pix_cnt   <= '0;
        lane_idx  <= '0;
        acc_data  <= '0;
        acc_keep  <= '0;
      end else if (pix) begin
        pix_cnt  <= eof ? '0 : pix_cnt + 32'd1;
        lane_idx <= done ? '0 : lane_idx + LW'(1);
        acc_data <= done ? '0 : nxt_data;
        acc_keep <= done ? '0 : nxt_keep;
      end
    end
  end
  assign empty = wr_ptr == rd_ptr;
  assign full  = wr_ptr[FIFO_AWIDTH] != rd_ptr[FIFO_AWIDTH] &&
                 wr_ptr[FIFO_AWIDTH-1:0] == rd_ptr[FIFO_AWIDTH-1:0];
  assign pop   = !empty && (!dn_valid || dn_ready);
  assign push  = push_val && (!full || pop);
  assign level = wr_ptr - rd_ptr;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AWIDTH-1:0]] <= push_word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_keep  <= '0;
      dn_last  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (FIFO_AWIDTH+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (FIFO_AWIDTH+1)'(1);
        {dn_data, dn_keep, dn_last} <= mem[rd_ptr[FIFO_AWIDTH-1:0]];
        dn_valid <= 1'b1;
      end else if (dn_ready) begin
        dn_valid <= 1'b0;
      end
      overflow <= cfg_wr ? 1'b0 : overflow || (push_val && !push);
    end
  end
endmodule
